// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - accumulates blocks of BLOCK_LEN adder sums into an ACC_W-bit total
// Define SUM_ACC_SAT_EN to saturate the total at all ones on overflow instead of wrapping.
module sum_accumulator #(
  parameter int ACC_W     = 8,
  parameter int BLOCK_LEN = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           S0,
  input  logic                           S1,
  input  logic                           S2,
  input  logic                           S3,
  input  logic                           Cout,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           clear,
  output logic [ACC_W-1:0]               acc_out,
  output logic                           ovf,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(BLOCK_LEN+1)-1:0] count
);

  localparam int            CW   = $clog2(BLOCK_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_LEN - 1);

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W:0]   v;
  logic [ACC_W:0]   sum;
  logic             accept;
  logic             last;

  // Operand is gated by in_valid so undriven adder bits never reach the adder.
  always_comb begin
    v   = '0;
    if (in_valid) begin
      v = {{(ACC_W - 4){1'b0}}, Cout, S3, S2, S1, S0};
    end
    sum = {1'b0, acc} + v;
`ifdef SUM_ACC_SAT_EN
    acc_nxt = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    acc_nxt = sum[ACC_W-1:0];
`endif
  end

  assign last = (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid & ~clear;
        if (accept && last) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ACCUM;
        end
      end
      default: begin
        state_nxt = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      acc_out <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (clear) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
          end else if (accept) begin
            ovf <= ovf | sum[ACC_W];
            if (last) begin
              acc_out <= acc_nxt;
              acc     <= '0;
              count   <= '0;
            end else begin
              acc   <= acc_nxt;
              count <= count + 1'b1;
            end
          end
        end
        HOLD: begin
          // acc_out keeps the last total after draining; only ovf is re-armed.
          if (out_ready) begin
            ovf <= 1'b0;
          end
        end
        default: begin
          acc <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - directed checks of sum_accumulator (ACC_W=8 and ACC_W=6 instances)
module tb_sum_accumulator;

  logic       clk;
  logic       rst_n;
  logic       S0, S1, S2, S3, Cout;
  logic       in_valid;
  logic       clear;
  logic       out_ready;

  logic       in_ready;
  logic [7:0] acc_out;
  logic       ovf;
  logic       out_valid;
  logic [2:0] count;

  logic       in_ready6;
  logic [5:0] acc_out6;
  logic       ovf6;
  logic       out_valid6;
  logic [2:0] count6;

  int checks;
  int failures;

  sum_accumulator #(.ACC_W(8), .BLOCK_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .S0(S0), .S1(S1), .S2(S2), .S3(S3), .Cout(Cout),
    .in_valid(in_valid), .in_ready(in_ready), .clear(clear),
    .acc_out(acc_out), .ovf(ovf), .out_valid(out_valid),
    .out_ready(out_ready), .count(count)
  );

  sum_accumulator #(.ACC_W(6), .BLOCK_LEN(4)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .S0(S0), .S1(S1), .S2(S2), .S3(S3), .Cout(Cout),
    .in_valid(in_valid), .in_ready(in_ready6), .clear(clear),
    .acc_out(acc_out6), .ovf(ovf6), .out_valid(out_valid6),
    .out_ready(out_ready), .count(count6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_v(input logic [4:0] val);
    {Cout, S3, S2, S1, S0} = val;
  endtask

  task automatic feed(input logic [4:0] val, input int n);
    set_v(val);
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    set_v(5'd0);
    step();
    step();
    rst_n = 1'b1;

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_acc_out", acc_out, 0);
    check("rst_ovf", ovf, 0);
    check("rst_count", count, 0);

    // Four sums of 1
    feed(5'd1, 3);
    check("ones_count3", count, 3);
    check("ones_not_done", out_valid, 0);
    feed(5'd1, 1);
    check("ones_out_valid", out_valid, 1);
    check("ones_acc_out", acc_out, 4);
    check("ones_ovf", ovf, 0);
    check("ones_in_ready_hold", in_ready, 0);
    check("ones_count_hold", count, 0);
    drain();
    check("ones_drained_valid", out_valid, 0);
    check("ones_drained_ready", in_ready, 1);

    // Adder 0001 + 1101 + 1 = 01111
    feed(5'b01111, 4);
    check("v15_acc_out", acc_out, 60);
    check("v15_ovf", ovf, 0);
    drain();

    // Two blocks of 31; the 6-bit instance overflows
    for (int b = 0; b < 2; b++) begin
      feed(5'd31, 4);
      check("v31_acc_out", acc_out, 124);
      check("v31_ovf", ovf, 0);
      check("v31_w6_valid", out_valid6, 1);
`ifdef SUM_ACC_SAT_EN
      check("v31_w6_acc_out", acc_out6, 63);
`else
      check("v31_w6_acc_out", acc_out6, 60);
`endif
      check("v31_w6_ovf", ovf6, 1);
      drain();
      check("v31_w6_ovf_cleared", ovf6, 0);
    end

    // Backpressure while upstream keeps offering v=5
    feed(5'd5, 4);
    check("bp_acc_out", acc_out, 20);
    set_v(5'd5);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("bp_acc_held", acc_out, 20);
    check("bp_count", count, 0);
    check("bp_valid", out_valid, 1);
    check("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release_count", count, 0);
    check("bp_release_ready", in_ready, 1);
    step();
    check("bp_first_accept", count, 1);
    step();
    step();
    step();
    in_valid = 1'b0;
    check("bp_block_acc_out", acc_out, 20);
    check("bp_block_valid", out_valid, 1);
    drain();

    // clear mid-block drops the concurrent sum
    feed(5'd3, 2);
    check("clr_count2", count, 2);
    set_v(5'd7);
    in_valid = 1'b1;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_count", count, 0);
    check("clr_ovf", ovf, 0);
    check("clr_ready", in_ready, 1);
    feed(5'd2, 4);
    check("clr_acc_out", acc_out, 8);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_hold_valid", out_valid, 1);
    check("clr_hold_acc_out", acc_out, 8);
    drain();

    // Idle cycles with undriven operand bits
    feed(5'd1, 2);
    {Cout, S3, S2, S1, S0} = 5'bxxxxx;
    for (int i = 0; i < 3; i++) step();
    check("idle_count", count, 2);
    feed(5'd1, 2);
    check("idle_acc_out", acc_out, 4);
    drain();

    // Reset while holding a result
    feed(5'b01111, 4);
    check("rsth_acc_out", acc_out, 60);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rsth_out_valid", out_valid, 0);
    check("rsth_acc_out0", acc_out, 0);
    check("rsth_ovf", ovf, 0);
    check("rsth_count", count, 0);
    check("rsth_in_ready", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
